// File: rtl/issue_queue.sv
// Collapsing out-of-order issue queue: entry 0 is always the oldest, one oldest-ready pick per FU.
// Optional macro IQ_SPECULATIVE_WAKEUP_EN lets same-cycle wakeup broadcasts qualify entries for select.
module issue_queue #(
    parameter int ENTRIES      = 8,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int PRN_BITS     = 6,
    parameter int INST_ID_BITS = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INST_ID_BITS-1:0]          in_inst_id,
    input  logic [31:0]                      in_raw_instr,
    input  logic [63:0]                      in_instr_pc,
    input  logic [$clog2(FU_COUNT)-1:0]      in_fu_choice,
    input  logic                             in_prn_input_valid  [MAX_OPERANDS],
    input  logic                             in_prn_input_ready  [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]              in_prn_input        [MAX_OPERANDS],
    input  logic                             in_prn_output_valid [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]              in_prn_output       [MAX_OPERANDS],
    input  logic                             set_prn_ready_valid [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]              set_prn_ready       [MAX_OPERANDS],
    input  logic                             flush,
    output logic                             issue_valid            [FU_COUNT],
    input  logic                             issue_ready            [FU_COUNT],
    output logic [INST_ID_BITS-1:0]          issue_inst_id          [FU_COUNT],
    output logic [31:0]                      issue_raw_instr        [FU_COUNT],
    output logic [63:0]                      issue_instr_pc         [FU_COUNT],
    output logic                             issue_prn_input_valid  [FU_COUNT][MAX_OPERANDS],
    output logic [PRN_BITS-1:0]              issue_prn_input        [FU_COUNT][MAX_OPERANDS],
    output logic                             issue_prn_output_valid [FU_COUNT][MAX_OPERANDS],
    output logic [PRN_BITS-1:0]              issue_prn_output       [FU_COUNT][MAX_OPERANDS],
    output logic [$clog2(ENTRIES+1)-1:0]     count
);

    localparam int FU_W  = $clog2(FU_COUNT);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    typedef struct packed {
        logic                                   valid;
        logic [INST_ID_BITS-1:0]                inst_id;
        logic [31:0]                            raw_instr;
        logic [63:0]                            instr_pc;
        logic [FU_W-1:0]                        fu;
        logic [MAX_OPERANDS-1:0]                src_valid;
        logic [MAX_OPERANDS-1:0]                src_rdy;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  src;
        logic [MAX_OPERANDS-1:0]                dst_valid;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  dst;
    } entry_t;

    entry_t                  q        [ENTRIES];
    entry_t                  q_next   [ENTRIES];
    logic [CNT_W-1:0]        count_next;
    logic [MAX_OPERANDS-1:0] hit      [ENTRIES];
    logic [MAX_OPERANDS-1:0] in_hit;
    logic [ENTRIES-1:0]      eligible;
    logic [ENTRIES-1:0]      remove;
    logic [FU_COUNT-1:0]     sel_found;
    logic [IDX_W-1:0]        sel_idx  [FU_COUNT];
    logic [FU_COUNT-1:0]     fire;
    logic                    enq_fire;

    function automatic logic prn_woken(input logic [PRN_BITS-1:0] prn);
        logic h;
        h = 1'b0;
        for (int unsigned k = 0; k < MAX_OPERANDS; k++)
            h = h | (set_prn_ready_valid[k] & (set_prn_ready[k] == prn));
        return h;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++)
            for (int unsigned s = 0; s < MAX_OPERANDS; s++)
                hit[i][s] = q[i].src_valid[s] & prn_woken(q[i].src[s]);
        for (int unsigned s = 0; s < MAX_OPERANDS; s++)
            in_hit[s] = in_prn_input_valid[s] & prn_woken(in_prn_input[s]);
    end

    always_comb begin
        logic [MAX_OPERANDS-1:0] eff;
        eff = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            eff = q[i].src_rdy | ~q[i].src_valid;
`ifdef IQ_SPECULATIVE_WAKEUP_EN
            eff = eff | hit[i];
`endif
            eligible[i] = q[i].valid & (&eff);
        end
    end

    // Lowest index wins, which is the oldest entry because the queue collapses toward 0.
    always_comb begin
        for (int unsigned f = 0; f < FU_COUNT; f++) begin
            sel_found[f] = 1'b0;
            sel_idx[f]   = '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (!sel_found[f] && eligible[i] && (q[i].fu == FU_W'(f))) begin
                    sel_found[f] = 1'b1;
                    sel_idx[f]   = IDX_W'(i);
                end
            end
        end
    end

    assign in_ready = (count < CNT_W'(ENTRIES)) & rst & ~flush;
    assign enq_fire = in_valid & in_ready;

    always_comb begin
        for (int unsigned f = 0; f < FU_COUNT; f++)
            fire[f] = rst & ~flush & sel_found[f] & issue_ready[f];
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            remove[i] = 1'b0;
            for (int unsigned f = 0; f < FU_COUNT; f++)
                if (fire[f] && (sel_idx[f] == IDX_W'(i)))
                    remove[i] = 1'b1;
        end
    end

    // Survivors are packed toward 0 in order; the write pointer then marks the enqueue slot.
    always_comb begin
        logic [CNT_W-1:0] wr;
        entry_t           e;
        wr = '0;
        e  = '0;
        for (int unsigned i = 0; i < ENTRIES; i++)
            q_next[i] = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (q[i].valid && !remove[i]) begin
                e         = q[i];
                e.src_rdy = q[i].src_rdy | hit[i];
                q_next[wr[IDX_W-1:0]] = e;
                wr = wr + 1'b1;
            end
        end
        if (enq_fire) begin
            e           = '0;
            e.valid     = 1'b1;
            e.inst_id   = in_inst_id;
            e.raw_instr = in_raw_instr;
            e.instr_pc  = in_instr_pc;
            e.fu        = in_fu_choice;
            for (int unsigned s = 0; s < MAX_OPERANDS; s++) begin
                e.src_valid[s] = in_prn_input_valid[s];
                e.src_rdy[s]   = in_prn_input_ready[s] | in_hit[s];
                e.src[s]       = in_prn_input[s];
                e.dst_valid[s] = in_prn_output_valid[s];
                e.dst[s]       = in_prn_output[s];
            end
            q_next[wr[IDX_W-1:0]] = e;
        end
        count_next = wr + CNT_W'(enq_fire);
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                q[i] <= '0;
            count <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                q[i] <= q_next[i];
            count <= count_next;
        end
    end

    always_comb begin
        entry_t p;
        for (int unsigned f = 0; f < FU_COUNT; f++) begin
            p = '0;
            if (rst && sel_found[f])
                p = q[sel_idx[f]];
            issue_valid[f]     = rst & sel_found[f];
            issue_inst_id[f]   = p.inst_id;
            issue_raw_instr[f] = p.raw_instr;
            issue_instr_pc[f]  = p.instr_pc;
            for (int unsigned s = 0; s < MAX_OPERANDS; s++) begin
                issue_prn_input_valid[f][s]  = p.src_valid[s];
                issue_prn_input[f][s]        = p.src[s];
                issue_prn_output_valid[f][s] = p.dst_valid[s];
                issue_prn_output[f][s]       = p.dst[s];
            end
        end
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

Unified out-of-order issue queue between `rename_stage` and the functional units. It holds renamed instructions until all valid source PRNs are ready, tracks readiness from FU wakeup broadcasts, and sends the oldest ready instruction per FU over a valid/ready port. Storage is a collapsing queue: entry 0 is always the oldest.

## Interface
Parameters:
- `ENTRIES`, 8: queue depth, ≥2.
- `MAX_OPERANDS`, 3: source and destination slots per instruction.
- `FU_COUNT`, 4: number of issue ports.
- `PRN_BITS`, 6: physical register number width.
- `INST_ID_BITS`, 6: ROB instruction id width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid` / `in_ready`  in/out  1  enqueue handshake.
- `in_inst_id`  in  INST_ID_BITS  ROB id.
- `in_raw_instr`  in  32  raw instruction word.
- `in_instr_pc`  in  64  instruction PC.
- `in_fu_choice`  in  $clog2(FU_COUNT)  target FU.
- `in_prn_input_valid[MAX_OPERANDS]`  in  1  source slot used.
- `in_prn_input_ready[MAX_OPERANDS]`  in  1  source already ready at rename.
- `in_prn_input[MAX_OPERANDS]`  in  PRN_BITS  source PRNs.
- `in_prn_output_valid[MAX_OPERANDS]` / `in_prn_output[MAX_OPERANDS]`  in  1/PRN_BITS  destination PRNs, stored and passed through unchanged.
- `set_prn_ready_valid[MAX_OPERANDS]` / `set_prn_ready[MAX_OPERANDS]`  in  1/PRN_BITS  wakeup broadcasts.
- `flush`  in  1  discard all entries.
- `issue_valid[FU_COUNT]` / `issue_ready[FU_COUNT]`  out/in  1  per-FU issue handshake.
- `issue_inst_id`, `issue_raw_instr`, `issue_instr_pc`, `issue_prn_input(_valid)`, `issue_prn_output(_valid)`  out  per FU  payload of the selected entry.
- `count`  out  $clog2(ENTRIES+1)  occupied entries.

## Operation
- Entry state: valid bit, payload, and per-source `rdy` bits.
- An unused source slot (`prn_input_valid=0`) is treated as ready.
- Enqueue: fires when `in_valid & in_ready`. `in_ready = (count < ENTRIES) & rst & !flush`. The new entry is written at index `count − issued_this_cycle`, i.e. after the collapse.
- Wakeup: for each valid broadcast `k`, any stored valid source whose PRN equals `set_prn_ready[k]` sets `rdy`. The incoming instruction's sources are also compared in the same cycle, so a broadcast in the enqueue cycle is not lost. Stored `rdy` = `in_prn_input_ready | match`.
- Select: for each FU `f`, the lowest-index valid entry with `fu_choice==f` and all sources ready. `issue_valid[f]` is high if such an entry exists, and the payload comes from that entry.
- Handshake: an entry is removed at the edge where `issue_valid[f] & issue_ready[f]`. If `issue_ready` is low, the entry stays and `issue_valid` stays high (the choice may change only if an older entry becomes ready).
- Collapse: surviving entries shift toward index 0 and keep their relative order. Up to FU_COUNT removals per cycle.
- Flush: on the next edge all valid bits clear and `count=0`. Enqueue and issue handshakes in a flush cycle are ignored. Flush takes priority over enqueue and issue.
- Reset (`rst=0` at an edge): all entries invalid, `count=0`. While `rst=0`: `in_ready=0`, all `issue_valid=0`, payload outputs 0.

## Timing
- Enqueue at edge N; the entry is selectable in cycle N+1 at the earliest.
- Wakeup broadcast in cycle N sets `rdy` at edge N; the entry issues in cycle N+1 (see Configuration for the same-cycle option).
- Issue outputs are combinational from registered state (plus wakeup when the macro is defined). No registered output stage.
- Full with a simultaneous issue: `in_ready` stays 0; no credit for same-cycle departures.

## Configuration
- `IQ_SPECULATIVE_WAKEUP_EN`:
  - Defined: the select logic ORs the current-cycle broadcast matches into `rdy`. An entry woken in cycle N can issue in cycle N.
  - Undefined: select uses stored `rdy` only, and issue happens in cycle N+1.
  - The enqueue-path wakeup capture is identical in both builds.

## Test plan
- Reset then single op: `rst=0` for 2 cycles, then enqueue id 5, fu 1, all sources ready. `issue_valid[1]=1` next cycle with `issue_inst_id=5`; with `issue_ready=1`, `count` returns 0.
- Wakeup: enqueue id 3 with source PRN 12 not ready; no issue. Broadcast PRN 12 in cycle T → `issue_valid` in cycle T+1 (T with macro defined).
- Same-cycle capture: enqueue with source PRN 9 not ready while broadcasting PRN 9. The entry issues the next cycle.
- Age order and backpressure: enqueue ids 1, 2, 3 to fu 0, all ready, `issue_ready[0]=0` for 3 cycles. `issue_inst_id` holds 1. Then release: ids 1, 2, 3 issue in order on consecutive cycles.
- Full: fill 8 entries → `in_ready=0`, `count=8`. An issue in the same cycle keeps `in_ready=0`; `in_ready=1` the following cycle, `count=7`.
- Flush: 5 entries plus a simultaneous enqueue and flush → `count=0` next cycle, no `issue_valid`, and the enqueued instruction is discarded.
